// File: rtl/btn_event_gen_pkg.sv
// Shared types for the button event generator: FSM state encoding and the one-hot event record.
// Also holds the default timing parameters used by the top level.
package btn_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  // At most one field is set in any cycle.
  typedef struct packed {
    logic press;
    logic rel;
    logic lng;
    logic rep;
  } evt_t;

  localparam int DEF_CNT_W         = 24;
  localparam int DEF_LONG_CYCLES   = 10_000_000;
  localparam int DEF_REPEAT_CYCLES = 2_500_000;
  localparam int DEF_COUNT_W       = 8;

endpackage

// File: rtl/btn_event_gen_if.sv
// Button level in, single-cycle events and press counter out.
// master = event generator side, slave = consumer (control/display FSMs).
interface btn_event_gen_if #(
  parameter int COUNT_W = 8
);
  logic               currentState;
  logic               pressPulse;
  logic               releasePulse;
  logic               longPulse;
  logic               repeatPulse;
  logic               held;
  logic [COUNT_W-1:0] pressCount;

  modport master (
    input  currentState,
    output pressPulse, releasePulse, longPulse, repeatPulse, held, pressCount
  );

  modport slave (
    output currentState,
    input  pressPulse, releasePulse, longPulse, repeatPulse, held, pressCount
  );
endinterface

// File: rtl/btn_event_gen_hold_timer.sv
// Free-running hold timer with synchronous clear (priority) and enable.
// Count is registered; one cycle from clr/en to the new value.
module btn_event_gen_hold_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clockSource,
  input  logic             resetN,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clockSource or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/btn_event_gen.sv
// Turns the debounced button level into press/release/long/repeat pulses plus a wrapping press count.
// Pulses appear one cycle after the sampling edge; no backpressure, every event is a 1-cycle pulse.
module btn_event_gen
  import btn_event_gen_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int COUNT_W       = DEF_COUNT_W
) (
  input  logic           clockSource,
  input  logic           resetN,
  btn_event_gen_if.master bus
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CNT_MAX ||
      REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_params
    $error("btn_event_gen: LONG_CYCLES/REPEAT_CYCLES outside 2..2^CNT_W-1");
  end

  state_t             state_q, state_d;
  evt_t               evt_q, evt_d;
  logic               lvl_q;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   timer;
  logic               tmr_clr, tmr_en;
  logic               rise, fall, long_hit, rep_hit;

  assign rise     = bus.currentState & ~lvl_q;
  assign fall     = ~bus.currentState & lvl_q;
  assign long_hit = (timer == LONG_LAST);
  assign rep_hit  = (timer == REP_LAST);

  btn_event_gen_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clockSource (clockSource),
    .resetN      (resetN),
    .clr_i       (tmr_clr),
    .en_i        (tmr_en),
    .count_o     (timer)
  );

  always_ff @(posedge clockSource or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      lvl_q   <= 1'b0;
      evt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= bus.currentState;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Release is checked before the terminal count so a fall always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rise) state_d = ST_SHORT;
      ST_SHORT: begin
        if (fall)          state_d = ST_IDLE;
        else if (long_hit) state_d = ST_LONG;
      end
      ST_LONG:  if (fall) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    evt_d   = '0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          evt_d.press = 1'b1;
          tmr_clr     = 1'b1;
          cnt_d       = cnt_q + COUNT_W'(1);
        end
      end
      ST_SHORT, ST_LONG: begin
        tmr_en = 1'b1;
        if (fall) begin
          evt_d.rel = 1'b1;
          tmr_clr   = 1'b1;
        end else if (state_q == ST_SHORT && long_hit) begin
          evt_d.lng = 1'b1;
          tmr_clr   = 1'b1;
        end else if (state_q == ST_LONG && rep_hit) begin
          evt_d.rep = 1'b1;
          tmr_clr   = 1'b1;
        end
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  assign bus.pressPulse   = evt_q.press;
  assign bus.releasePulse = evt_q.rel;
  assign bus.longPulse    = evt_q.lng;
  assign bus.repeatPulse  = evt_q.rep;
  assign bus.held         = (state_q != ST_IDLE);
  assign bus.pressCount   = cnt_q;

endmodule
